// File: rtl/controlador_tx_uart.sv
// Shares one UART transmitter between two requesters (A: sensor responses, B: status/errors).
// Sends two-byte frames with round-robin grant and aborts with a pulse if the transmitter stalls.
module controlador_tx_uart #(
  parameter int CLOKS_POR_BIT  = 5209,
  parameter int TIMEOUT_CICLOS = 65000
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       reqA,
  input  logic       reqB,
  input  logic [7:0] byte1A,
  input  logic [7:0] byte2A,
  input  logic [7:0] byte1B,
  input  logic [7:0] byte2B,
  output logic       ackA,
  output logic       ackB,
  output logic       txInicio,
  output logic [7:0] txByte1,
  output logic [7:0] txByte2,
  input  logic       txOcupado,
  input  logic       txConcluido,
  output logic       ocupado,
  output logic       erroTimeout
);

  localparam int LARG_CONT = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [LARG_CONT-1:0] LIMITE    = LARG_CONT'(TIMEOUT_CICLOS);
  localparam logic [LARG_CONT-1:0] LIMITE_M1 = LARG_CONT'(TIMEOUT_CICLOS - 1);

  // A whole byte (start + 8 data + stop) must fit inside the timeout window.
  if (TIMEOUT_CICLOS <= 10 * CLOKS_POR_BIT) begin : gChecaParam
    $error("TIMEOUT_CICLOS must exceed 10*CLOKS_POR_BIT");
  end

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    ENVIA1    = 3'd1,
    ESPERA1   = 3'd2,
    INTERVALO = 3'd3,
    ENVIA2    = 3'd4,
    ESPERA2   = 3'd5,
    GUARDA    = 3'd6,
    CONCLUI   = 3'd7
  } estado_t;

  estado_t              estado_r;
  logic [LARG_CONT-1:0] contTimeout_r;
  logic                 txConcluidoAnt_r;
  logic                 ponteiroB_r;
  logic                 donoB_r;
  logic                 bordaConcluido_s;
  logic                 haPedido_s;
  logic                 concedeB_s;

  assign bordaConcluido_s = txConcluido & ~txConcluidoAnt_r;
  assign haPedido_s       = reqA | reqB;
  // B wins when it is alone, or when both ask and the pointer selects B.
  assign concedeB_s       = reqB & (~reqA | ponteiroB_r);

  // Registered copy of txConcluido for rising-edge detection.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      txConcluidoAnt_r <= 1'b0;
    end else begin
      txConcluidoAnt_r <= txConcluido;
    end
  end

  // Frame sequencer: grant, two start pulses, done handshakes, ack or timeout abort.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      estado_r      <= OCIOSO;
      contTimeout_r <= {LARG_CONT{1'b0}};
      ponteiroB_r   <= 1'b0;
      donoB_r       <= 1'b0;
      ackA          <= 1'b0;
      ackB          <= 1'b0;
      txInicio      <= 1'b0;
      txByte1       <= 8'h00;
      txByte2       <= 8'h00;
      ocupado       <= 1'b0;
      erroTimeout   <= 1'b0;
    end else begin
      txInicio    <= 1'b0;
      ackA        <= 1'b0;
      ackB        <= 1'b0;
      erroTimeout <= 1'b0;
      case (estado_r)
        OCIOSO: begin
          if (haPedido_s) begin
            estado_r      <= ENVIA1;
            txInicio      <= 1'b1;
            ocupado       <= 1'b1;
            donoB_r       <= concedeB_s;
            contTimeout_r <= {LARG_CONT{1'b0}};
            txByte1       <= concedeB_s ? byte1B : byte1A;
            txByte2       <= concedeB_s ? byte2B : byte2A;
            if (reqA && reqB) begin
              ponteiroB_r <= ~ponteiroB_r;
            end
          end
        end
        ENVIA1: estado_r <= ESPERA1;
        ESPERA1, ESPERA2: begin
          if (bordaConcluido_s) begin
            estado_r <= (estado_r == ESPERA1) ? INTERVALO : GUARDA;
          end else if (contTimeout_r >= LIMITE_M1) begin
            // Counter lands exactly on the limit and stays there until the next start.
            contTimeout_r <= LIMITE;
            erroTimeout   <= 1'b1;
            ocupado       <= 1'b0;
            estado_r      <= OCIOSO;
          end else begin
            contTimeout_r <= contTimeout_r + 1'b1;
          end
        end
        INTERVALO: begin
          if (!txConcluido && !txOcupado) begin
            estado_r      <= ENVIA2;
            txInicio      <= 1'b1;
            contTimeout_r <= {LARG_CONT{1'b0}};
          end
        end
        ENVIA2: estado_r <= ESPERA2;
        GUARDA: begin
          if (!txConcluido) begin
            estado_r <= CONCLUI;
            ackA     <= ~donoB_r;
            ackB     <= donoB_r;
            ocupado  <= 1'b0;
          end
        end
        CONCLUI: estado_r <= OCIOSO;
        default: begin
          estado_r <= OCIOSO;
          ocupado  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_tx_uart.sv
// Bench for controlador_tx_uart: behavioural UART transmitter plus serial receiver,
// with byte/frame/ack scoreboards filled when stimulus is driven.
module tb_controlador_tx_uart;

  localparam int CPB = 4;
  localparam int TMO = 60;

  logic       clock = 1'b0;
  logic       resetN;
  logic       reqA, reqB;
  logic [7:0] byte1A, byte2A, byte1B, byte2B;
  logic       ackA, ackB, txInicio, ocupado, erroTimeout;
  logic [7:0] txByte1, txByte2;
  logic       txOcupado, txConcluido, linha;

  int nChecks = 0;
  int nErrors = 0;

  logic [7:0]  expByteQ[$];
  logic [15:0] expFrameQ[$];
  logic        expAckQ[$];

  controlador_tx_uart #(.CLOKS_POR_BIT(CPB), .TIMEOUT_CICLOS(TMO)) dut (
    .clock(clock), .resetN(resetN), .reqA(reqA), .reqB(reqB),
    .byte1A(byte1A), .byte2A(byte2A), .byte1B(byte1B), .byte2B(byte2B),
    .ackA(ackA), .ackB(ackB), .txInicio(txInicio), .txByte1(txByte1), .txByte2(txByte2),
    .txOcupado(txOcupado), .txConcluido(txConcluido), .ocupado(ocupado),
    .erroTimeout(erroTimeout)
  );

  always #5 clock = ~clock;

  // Transmitter model: alternates first/second byte, done high 2 cycles after the stop bit.
  logic       modeloRst = 1'b1;
  logic       travaConcluido = 1'b0;
  logic       mOcup, mSel;
  logic [9:0] mShift;
  logic [3:0] mBit;
  logic [1:0] mDone;
  int         mDiv;

  always @(posedge clock) begin
    if (modeloRst) begin
      mOcup <= 1'b0; mSel <= 1'b0; mShift <= 10'h3FF; mBit <= 4'd0; mDone <= 2'd0; mDiv <= 0;
    end else begin
      if (mDone != 2'd0) mDone <= mDone - 2'd1;
      if (txInicio && !mOcup) begin
        mShift <= {1'b1, (mSel ? txByte2 : txByte1), 1'b0};
        mSel   <= ~mSel;
        mOcup  <= 1'b1;
        mDiv   <= 0;
        mBit   <= 4'd0;
      end else if (mOcup) begin
        if (mDiv == CPB - 1) begin
          mDiv <= 0;
          if (mBit == 4'd9) begin
            mOcup <= 1'b0;
            mDone <= 2'd2;
          end else begin
            mBit   <= mBit + 4'd1;
            mShift <= mShift >> 1;
          end
        end else begin
          mDiv <= mDiv + 1;
        end
      end
    end
  end

  assign linha       = mOcup ? mShift[0] : 1'b1;
  assign txOcupado   = mOcup;
  assign txConcluido = (mDone != 2'd0) && !travaConcluido;

  // Serial receiver: samples mid-bit, checks stop bit and byte against the scoreboard.
  initial begin
    logic [7:0] rx;
    logic [7:0] esperado;
    forever begin
      @(negedge clock);
      if (linha === 1'b0) begin
        repeat (CPB / 2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          rx[i] = linha;
        end
        repeat (CPB) @(negedge clock);
        nChecks++;
        if (linha !== 1'b1) begin
          nErrors++; $display("FAIL stop_bit got %b want 1", linha);
        end
        nChecks++;
        if (expByteQ.size() == 0) begin
          nErrors++; $display("FAIL serial_byte got %h want none", rx);
        end else begin
          esperado = expByteQ.pop_front();
          if (rx !== esperado) begin
            nErrors++; $display("FAIL serial_byte got %h want %h", rx, esperado);
          end
        end
      end
    end
  end

  // Protocol monitor: start pulse spacing, frame bytes, pulses per frame, ack owner/width.
  initial begin
    int          pulsosFrame;
    logic        antConc, antOcup, antAck, dono;
    logic [15:0] frameAtual;
    pulsosFrame = 0; antConc = 1'b0; antOcup = 1'b0; antAck = 1'b0; frameAtual = 16'h0000;
    forever begin
      @(negedge clock);
      if (resetN !== 1'b1) begin
        pulsosFrame = 0;
      end else begin
        if (txInicio) begin
          nChecks++;
          if (antConc !== 1'b0 || antOcup !== 1'b0 || pulsosFrame >= 2) begin
            nErrors++;
            $display("FAIL start_pulse got conc=%b ocup=%b pulses=%0d want 0/0/<2", antConc, antOcup, pulsosFrame);
          end
          if (pulsosFrame == 0) begin
            nChecks++;
            if (expFrameQ.size() == 0) begin
              nErrors++; $display("FAIL frame_grant got %h%h want none", txByte1, txByte2);
            end else begin
              frameAtual = expFrameQ.pop_front();
            end
          end
          nChecks++;
          if ({txByte1, txByte2} !== frameAtual) begin
            nErrors++; $display("FAIL frame_bytes got %h%h want %h", txByte1, txByte2, frameAtual);
          end
          pulsosFrame++;
        end
        if (erroTimeout) pulsosFrame = 0;
        if (ackA || ackB) begin
          nChecks++;
          if (expAckQ.size() == 0) begin
            nErrors++; $display("FAIL ack_owner got A=%b B=%b want none", ackA, ackB);
          end else begin
            dono = expAckQ.pop_front();
            if (ackA !== ~dono || ackB !== dono) begin
              nErrors++; $display("FAIL ack_owner got A=%b B=%b want B=%b", ackA, ackB, dono);
            end
          end
          nChecks++;
          if (pulsosFrame != 2 || antAck) begin
            nErrors++; $display("FAIL ack_frame got pulses=%0d prevAck=%b want 2/0", pulsosFrame, antAck);
          end
          pulsosFrame = 0;
        end
      end
      antConc = txConcluido; antOcup = txOcupado; antAck = ackA | ackB;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic aplicaReset();
    resetN = 1'b0; modeloRst = 1'b1; reqA = 1'b0; reqB = 1'b0;
    repeat (3) @(negedge clock);
    resetN = 1'b1; modeloRst = 1'b0;
    @(negedge clock);
  endtask

  task automatic esperaAcks(input int n, input int limite, output bit ok);
    int vistos = 0;
    for (int c = 0; c < limite && vistos < n; c++) begin
      @(negedge clock);
      if (ackA || ackB) vistos++;
    end
    ok = (vistos >= n);
  endtask

  task automatic test_reset();
    resetN = 1'b0; reqA = 1'b0; reqB = 1'b0;
    byte1A = 8'h00; byte2A = 8'h00; byte1B = 8'h00; byte2B = 8'h00;
    #1;
    nChecks++;
    if ({ackA, ackB, txInicio, txByte1, txByte2, ocupado, erroTimeout} !== 21'd0) begin
      nErrors++; $display("FAIL reset_outputs got %h want 0",
                          {ackA, ackB, txInicio, txByte1, txByte2, ocupado, erroTimeout});
    end
    aplicaReset();
    repeat (3) @(negedge clock);
    nChecks++;
    if ({ackA, ackB, txInicio, ocupado, erroTimeout} !== 5'd0) begin
      nErrors++; $display("FAIL idle_outputs got %b want 0", {ackA, ackB, txInicio, ocupado, erroTimeout});
    end
  endtask

  task automatic test_basic();
    bit ok;
    byte1A = 8'h25; byte2A = 8'h3C; byte1B = 8'h77; byte2B = 8'h88;
    expByteQ.push_back(8'h25); expByteQ.push_back(8'h3C);
    expFrameQ.push_back(16'h253C); expAckQ.push_back(1'b0);
    reqA = 1'b1;
    @(negedge clock);
    nChecks++;
    if (txInicio !== 1'b1 || ocupado !== 1'b1) begin
      nErrors++; $display("FAIL grant_latency got start=%b busy=%b want 1/1", txInicio, ocupado);
    end
    reqA = 1'b0;
    esperaAcks(1, 400, ok);
    nChecks++;
    if (!ok) begin nErrors++; $display("FAIL basic_ack got none want ackA"); end
    repeat (3) @(negedge clock);
    nChecks++;
    if (expByteQ.size() != 0 || expAckQ.size() != 0) begin
      nErrors++; $display("FAIL basic_drain got bytes=%0d acks=%0d want 0/0", expByteQ.size(), expAckQ.size());
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    aplicaReset();
    byte1A = 8'h11; byte2A = 8'h22; byte1B = 8'h33; byte2B = 8'h44;
    for (int k = 0; k < 2; k++) begin
      expByteQ.push_back(8'h11); expByteQ.push_back(8'h22);
      expByteQ.push_back(8'h33); expByteQ.push_back(8'h44);
      expFrameQ.push_back(16'h1122); expFrameQ.push_back(16'h3344);
      expAckQ.push_back(1'b0); expAckQ.push_back(1'b1);
    end
    reqA = 1'b1; reqB = 1'b1;
    esperaAcks(4, 1200, ok);
    reqA = 1'b0; reqB = 1'b0;
    nChecks++;
    if (!ok) begin nErrors++; $display("FAIL rr_acks got fewer want 4"); end
    repeat (5) @(negedge clock);
    nChecks++;
    if (ocupado !== 1'b0 || expByteQ.size() != 0 || expAckQ.size() != 0) begin
      nErrors++; $display("FAIL rr_drain got busy=%b bytes=%0d acks=%0d want 0/0/0",
                          ocupado, expByteQ.size(), expAckQ.size());
    end
  endtask

  task automatic test_sample();
    bit ok;
    byte1A = 8'h81; byte2A = 8'h5A;
    expByteQ.push_back(8'h81); expByteQ.push_back(8'h5A);
    expFrameQ.push_back(16'h815A); expAckQ.push_back(1'b0);
    reqA = 1'b1;
    @(negedge clock);
    reqA = 1'b0; byte1A = 8'hFF; byte2A = 8'hFF;
    esperaAcks(1, 400, ok);
    nChecks++;
    if (!ok) begin nErrors++; $display("FAIL sample_ack got none want ackA"); end
    repeat (3) @(negedge clock);
    nChecks++;
    if (expByteQ.size() != 0) begin
      nErrors++; $display("FAIL sample_drain got bytes=%0d want 0", expByteQ.size());
    end
  endtask

  task automatic test_timeout();
    int ciclos = 0;
    int pulsos = 0;
    travaConcluido = 1'b1;
    byte1A = 8'hC5; byte2A = 8'h5C;
    expByteQ.push_back(8'hC5); expFrameQ.push_back(16'hC55C);
    reqA = 1'b1;
    @(negedge clock);
    reqA = 1'b0;
    // The start pulse is visible now; ESPERA1 begins next cycle and the abort lands 60 cycles into it.
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      if (erroTimeout) begin ciclos = c; break; end
    end
    nChecks++;
    if (ciclos != TMO + 1) begin
      nErrors++; $display("FAIL timeout_delay got %0d want %0d", ciclos, TMO + 1);
    end
    nChecks++;
    if (ocupado !== 1'b0 || ackA !== 1'b0) begin
      nErrors++; $display("FAIL timeout_outputs got busy=%b ack=%b want 0/0", ocupado, ackA);
    end
    @(negedge clock);
    nChecks++;
    if (erroTimeout !== 1'b0) begin
      nErrors++; $display("FAIL timeout_width got %b want 0", erroTimeout);
    end
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (txInicio) pulsos++;
    end
    nChecks++;
    if (pulsos != 0 || expByteQ.size() != 0 || expAckQ.size() != 0) begin
      nErrors++; $display("FAIL timeout_quiet got pulses=%0d bytes=%0d want 0/0", pulsos, expByteQ.size());
    end
    travaConcluido = 1'b0; modeloRst = 1'b1;
    repeat (2) @(negedge clock);
    modeloRst = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulsos = 0;
    byte1A = 8'h5A; byte2A = 8'hA5;
    expByteQ.push_back(8'h5A); expByteQ.push_back(8'hA5); expFrameQ.push_back(16'h5AA5);
    reqA = 1'b1;
    @(negedge clock);
    reqA = 1'b0;
    pulsos = 1;
    for (int c = 0; c < 300 && pulsos < 2; c++) begin
      @(negedge clock);
      if (txInicio) pulsos++;
    end
    repeat (5) @(negedge clock);
    nChecks++;
    if (pulsos != 2 || ocupado !== 1'b1) begin
      nErrors++; $display("FAIL midreset_setup got pulses=%0d busy=%b want 2/1", pulsos, ocupado);
    end
    #2 resetN = 1'b0;
    #1;
    nChecks++;
    if ({ackA, ackB, txInicio, txByte1, txByte2, ocupado, erroTimeout} !== 21'd0) begin
      nErrors++; $display("FAIL midreset_outputs got %h want 0",
                          {ackA, ackB, txInicio, txByte1, txByte2, ocupado, erroTimeout});
    end
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    pulsos = 0;
    for (int c = 0; c < 11 * CPB + 10; c++) begin
      @(negedge clock);
      if (txInicio || ackA || ackB) pulsos++;
    end
    nChecks++;
    if (pulsos != 0 || expByteQ.size() != 0) begin
      nErrors++; $display("FAIL midreset_quiet got events=%0d bytes=%0d want 0/0", pulsos, expByteQ.size());
    end
  endtask

  task automatic test_done_wide();
    int   pulsos = 0;
    int   altos = 0;
    bit   acabou = 1'b0;
    logic antConc = 1'b0;
    logic antOcup = 1'b0;
    byte1A = 8'hC3; byte2A = 8'h3C;
    expByteQ.push_back(8'hC3); expByteQ.push_back(8'h3C);
    expFrameQ.push_back(16'hC33C); expAckQ.push_back(1'b0);
    reqA = 1'b1;
    @(negedge clock);
    reqA = 1'b0;
    pulsos = 1;
    for (int c = 0; c < 400 && !acabou; c++) begin
      antConc = txConcluido; antOcup = txOcupado;
      @(negedge clock);
      if (txConcluido) altos++;
      if (txInicio) begin
        pulsos++;
        nChecks++;
        if (antConc !== 1'b0 || antOcup !== 1'b0) begin
          nErrors++; $display("FAIL second_start got conc=%b ocup=%b want 0/0", antConc, antOcup);
        end
      end
      if (ackA) acabou = 1'b1;
    end
    nChecks++;
    if (!acabou || pulsos != 2 || altos != 4) begin
      nErrors++; $display("FAIL wide_done got ack=%b pulses=%0d doneCycles=%0d want 1/2/4", acabou, pulsos, altos);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_sample();
    test_timeout();
    test_reset_mid();
    test_done_wide();
    repeat (5) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
